// File: rtl/clk_div_bank.sv
// ============================================================================
// Module   : clk_div_bank
// Brief    : Multi-channel programmable divider and tick generator with
//            a free-running cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div,
    input  logic [NUM_CH*CNT_W-1:0] high,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pend,
    output logic [CNT_W-1:0]        count
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_pa, r_ha, r_pp, r_hp, r_ph;
            logic             r_pend, r_run, r_tick, r_clk;
            logic [CNT_W-1:0] w_div, w_high, w_np, w_nh, w_pe, w_he;
            logic [CNT_W-1:0] w_ph_nx, w_hmin;
            logic             w_wrap, w_apply, w_run_nx, w_restart;

            always_comb begin
                w_div     = div[i*CNT_W +: CNT_W];
                w_high    = high[i*CNT_W +: CNT_W];
                w_wrap    = r_run && (r_ph == (r_pa - c_ONE));
                // A load on the same edge as an apply bypasses the pending regs.
                w_np      = load[i] ? w_div  : r_pp;
                w_nh      = load[i] ? w_high : r_hp;
                w_apply   = (load[i] || r_pend) && (!r_run || sync || w_wrap);
                w_pe      = w_apply ? w_np : r_pa;
                w_he      = w_apply ? w_nh : r_ha;
                w_run_nx  = en[i] && (w_pe != '0);
                w_restart = !r_run || sync || w_wrap;
                w_ph_nx   = (!w_run_nx || w_restart) ? '0 : (r_ph + c_ONE);
                w_hmin    = (w_he < w_pe) ? w_he : w_pe;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pa   <= '0;
                    r_ha   <= '0;
                    r_pp   <= '0;
                    r_hp   <= '0;
                    r_ph   <= '0;
                    r_pend <= 1'b0;
                    r_run  <= 1'b0;
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                end else begin
                    if (load[i]) begin
                        r_pp <= w_div;
                        r_hp <= w_high;
                    end
                    if (w_apply) begin
                        r_pa   <= w_np;
                        r_ha   <= w_nh;
                        r_pend <= 1'b0;
                    end else if (load[i]) begin
                        r_pend <= 1'b1;
                    end
                    r_run  <= w_run_nx;
                    r_ph   <= w_ph_nx;
                    // Outputs decode the next phase so they align with it.
                    r_tick <= w_run_nx && (w_ph_nx == '0);
                    r_clk  <= w_run_nx && (w_ph_nx < w_hmin);
                end
            end

            assign clk_out[i] = r_clk;
            assign tick[i]    = r_tick;
            assign pend[i]    = r_pend;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Self-checking bench for clk_div_bank against a time-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 12;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH*CNT_W-1:0] div = '0;
    logic [NUM_CH*CNT_W-1:0] high = '0;
    logic [NUM_CH-1:0]       load = '0;
    logic                    sync = 1'b0;
    logic [NUM_CH-1:0]       clk_out, tick, pend;
    logic [CNT_W-1:0]        count;

    clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div(div), .high(high),
        .load(load), .sync(sync), .clk_out(clk_out), .tick(tick),
        .pend(pend), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, n_edge);
    endtask

    // Model: each channel remembers the edge index where its current period
    // began; the phase is simply the elapsed edge count modulo the period.
    int          n_edge = 0;
    int          m_pa[NUM_CH], m_ha[NUM_CH], m_pp[NUM_CH], m_hp[NUM_CH], m_ts[NUM_CH];
    bit          m_pend[NUM_CH], m_run[NUM_CH];
    logic [NUM_CH-1:0] e_tick = '0, e_clk = '0, e_pend = '0;
    int          e_cnt = 0;

    function automatic void model();
        int  d, h, ph;
        bit  wrap, apply;
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_pa[c] = 0; m_ha[c] = 0; m_pp[c] = 0; m_hp[c] = 0;
                m_ts[c] = 0; m_pend[c] = 0; m_run[c] = 0;
            end
            e_tick = '0; e_clk = '0; e_pend = '0; e_cnt = 0;
            return;
        end
        e_cnt = (e_cnt + 1) % (1 << CNT_W);
        for (int c = 0; c < NUM_CH; c++) begin
            d     = int'(div[c*CNT_W +: CNT_W]);
            h     = int'(high[c*CNT_W +: CNT_W]);
            wrap  = m_run[c] && (((n_edge - m_ts[c]) % m_pa[c]) == 0);
            apply = (load[c] || m_pend[c]) && (!m_run[c] || sync || wrap);
            if (load[c]) begin
                m_pp[c] = d;
                m_hp[c] = h;
            end
            if (apply) begin
                m_pa[c] = m_pp[c]; m_ha[c] = m_hp[c]; m_pend[c] = 0;
            end else if (load[c]) begin
                m_pend[c] = 1;
            end
            if (!en[c] || m_pa[c] == 0) begin
                m_run[c] = 0;
                e_tick[c] = 1'b0;
                e_clk[c]  = 1'b0;
            end else begin
                if (!m_run[c] || sync || wrap) m_ts[c] = n_edge;
                m_run[c] = 1;
                ph = (n_edge - m_ts[c]) % m_pa[c];
                e_tick[c] = (ph == 0);
                e_clk[c]  = (ph < m_ha[c]) && (ph < m_pa[c]);
            end
            e_pend[c] = m_pend[c];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        n_edge++;
        model();
        #1;
        chk("tick", 32'(tick), 32'(e_tick));
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("pend", 32'(pend), 32'(e_pend));
        chk("count", 32'(count), 32'(e_cnt));
        load = '0;
        sync = 1'b0;
    endtask

    task automatic cfg(input int c, input int p, input int h);
        div[c*CNT_W +: CNT_W]  = CNT_W'(p);
        high[c*CNT_W +: CNT_W] = CNT_W'(h);
        load[c] = 1'b1;
    endtask

    function automatic int ph_of(input int c);
        return (n_edge - m_ts[c]) % ((m_pa[c] == 0) ? 1 : m_pa[c]);
    endfunction

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk("rst_outs", 32'({clk_out, tick, pend}), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        // ch0 P=4 H=2, then enable
        cfg(0, 4, 2);
        step();
        en[0] = 1'b1;
        step();
        chk("first_tick", 32'(tick[0]), 32'd1);
        chk("first_clk", 32'(clk_out[0]), 32'd1);
        repeat (12) step();

        // ch1 P=5 with H=0 then H=9
        cfg(1, 5, 0);
        en[1] = 1'b1;
        step();
        repeat (11) step();
        cfg(1, 5, 9);
        step();
        repeat (11) step();

        // ch0 reconfigured to P=6 at phase 1
        for (int k = 0; k < 10 && ph_of(0) != 1; k++) step();
        cfg(0, 6, 3);
        step();
        chk("pend_set", 32'(pend[0]), 32'd1);
        repeat (14) step();

        // ch0 back to P=4, ch2 P=6, then sync
        cfg(0, 4, 2);
        cfg(2, 6, 3);
        en[2] = 1'b1;
        step();
        repeat (3) step();
        sync = 1'b1;
        step();
        chk("sync_tick", 32'(tick & 4'b0101), 32'h5);
        repeat (13) step();

        // stop during high phase, restart, then reset mid-period
        for (int k = 0; k < 10 && clk_out[0] !== 1'b1; k++) step();
        en[0] = 1'b0;
        step();
        chk("stop_clk", 32'(clk_out[0]), 32'd0);
        chk("stop_tick", 32'(tick[0]), 32'd0);
        en[0] = 1'b1;
        step();
        chk("restart_tick", 32'(tick[0]), 32'd1);
        cfg(3, 7, 3);
        step();
        cfg(3, 5, 1);
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid", 32'({clk_out, tick, pend}), 32'd0);
        rst_n = 1'b1;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 7) == 0) cfg(c, $urandom_range(0, 7), $urandom_range(0, 9));
            end
            sync  = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        // counter wrap
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4096) step();
        chk("cnt_wrap0", 32'(count), 32'd0);
        repeat (3) step();
        chk("cnt_3", 32'(count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
